sdram_port_sched: RTL and testbench
===================================

SDRAM_PORT_SCHED -- requirements
Module: sdram_port_sched

Interface
REQ-001 Parameter ADDR_W, default 24: SDRAM word-address width.
REQ-002 Parameter WR_LEN, default 256: burst length in words for write ports 0 and 1.
REQ-003 Parameter RD_LEN, default 128: burst length in words for read ports 2 and 3.
REQ-004 Parameter BUF_A_BASE, default 0: base of buffer A (gray frame), used by ports 0 (WR1) and 2 (RD1).
REQ-005 Parameter BUF_B_BASE, default 307200: base of buffer B (marked RGB565 frame), used by ports 1 (WR2) and 3 (RD2).
REQ-006 Parameter FRAME_WORDS, default 307200: buffer size in words (640*480).
REQ-007 clk  in  1  100 MHz SDRAM reference clock; all logic on its rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 init_done  in  1  SDRAM power-up sequence complete.
REQ-010 req  in  4  per-port level request: write FIFO holds at least one burst, or read FIFO has room for one burst.
REQ-011 load  in  4  per-port synchronous pulse: reload that port's address pointer to its base.
REQ-012 cmd_valid  out  1  burst command presented.
REQ-013 cmd_ready  in  1  command engine accepts the command.
REQ-014 cmd_write  out  1  1 = write burst, 0 = read burst.
REQ-015 cmd_port  out  2  granted port index.
REQ-016 cmd_addr  out  ADDR_W  burst start address.
REQ-017 cmd_len  out  9  burst length (WR_LEN or RD_LEN).
REQ-018 burst_done  in  1  one-cycle pulse: command engine finished the accepted burst.
REQ-019 grant  out  4  one-hot; set from command issue through burst_done, drives FIFO-side data steering.
REQ-020 frame_wrap  out  4  one-cycle pulse per port when its pointer wraps to base.

Function
REQ-021 FSM states are IDLE, CMD and WAIT.
REQ-022 IDLE: if init_done=1 and req!=0, the block selects a winner round-robin, searching from (last_port+1) mod 4 upward, and enters CMD on the next cycle.
REQ-023 Latency: req sampled in IDLE at cycle N gives registered cmd_valid=1, with cmd_port, cmd_write, cmd_addr, cmd_len and grant, at cycle N+1.
REQ-024 CMD: all cmd_* outputs are held stable until the cycle cmd_valid&cmd_ready, then the FSM enters WAIT; cmd_valid=0 from the next cycle.
REQ-025 WAIT: grant is held until burst_done; then last_port is set to the winner, grant clears and the FSM returns to IDLE, giving at least 1 IDLE cycle between bursts.
REQ-026 cmd_write=1 for ports 0 and 1 and 0 for ports 2 and 3; cmd_len follows the same split.
REQ-027 Pointer update on burst_done: next = ptr + len, computed ADDR_W+1 wide; if next >= base+FRAME_WORDS then ptr = base and frame_wrap[port] pulses for 1 cycle, otherwise ptr = next.
REQ-028 load[i] with port i not granted sets ptr[i] = base on the next cycle.
REQ-029 load[i] while port i is granted leaves cmd_addr unchanged, is recorded, and is applied at burst_done in place of the increment, with no frame_wrap pulse.
REQ-030 A req drop after the grant is ignored; the issued burst completes.
REQ-031 init_done falling mid-burst lets the current burst finish; no new grant is made while init_done=0.
REQ-032 burst_done in IDLE or CMD is ignored.
REQ-033 cmd_ready outside CMD is ignored.

Reset
REQ-034 On rst_n=0, asynchronously: state=IDLE, cmd_valid=0, cmd_write=0, cmd_port=0, cmd_addr=0, cmd_len=0, grant=0, frame_wrap=0, last_port=3 (port 0 wins first), ptr[0]=ptr[2]=BUF_A_BASE, ptr[1]=ptr[3]=BUF_B_BASE, pending loads cleared.
REQ-035 Reset asserted mid-burst aborts the burst; no pointer update occurs.

Structure
REQ-036 Package sdram_sched_pkg holds the port index constants (WR1=0, WR2=1, RD1=2, RD2=3), the FSM state enumeration and the cmd_len width constant.
REQ-037 Sub-module rr_arb4 is combinational and maps req[3:0] and last_port to a one-hot winner and an index; all other logic stays in sdram_port_sched.

Verification
REQ-038 Reset, init_done=1, req=4'b1111, cmd_ready=1, burst_done 10 cycles after each accept -> grant order 0,1,2,3,0; first cmd_addr per port 0, 307200, 0, 307200; cmd_len 256, 256, 128, 128.
REQ-039 init_done=0 with req=4'b0001 -> cmd_valid stays 0; init_done rises -> cmd_valid=1 two cycles later.
REQ-040 ptr[0] preset near top by 1199 bursts, then one more burst_done -> next = 307200 >= 307200 -> ptr[0]=0, frame_wrap[0] 1-cycle pulse.
REQ-041 cmd_ready held 0 for 5 cycles -> cmd_* stable and cmd_valid=1 for all 5 cycles; accept on cycle 6 -> WAIT.
REQ-042 load[3] during a port-3 burst at ptr=307328 -> cmd_addr unchanged; after burst_done ptr[3]=307200; next port-3 cmd_addr=307200; no frame_wrap pulse.
REQ-043 rst_n low during WAIT -> all outputs reset values next edge; after release port 0 wins first at cmd_addr 0.

Source files
------------

// File: rtl/sdram_sched_pkg.sv
// Shared constants for the SDRAM port scheduler: port indices, FSM states
// and the burst-length field width.
package sdram_sched_pkg;

  localparam logic [1:0] WR1 = 2'd0;
  localparam logic [1:0] WR2 = 2'd1;
  localparam logic [1:0] RD1 = 2'd2;
  localparam logic [1:0] RD2 = 2'd3;

  localparam int CMD_LEN_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter: searches upward from the port
// after last_port_i and returns the first requester as one-hot and index.
module rr_arb4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_port_i,
  output logic [3:0] win_oh_o,
  output logic [1:0] win_idx_o,
  output logic       win_vld_o
);

  logic [1:0] cand;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    win_oh_o  = '0;
    win_idx_o = 2'd0;
    win_vld_o = 1'b0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_port_i + 2'(k);
      if (!win_vld_o && req_i[cand]) begin
        win_vld_o = 1'b1;
        win_idx_o = cand;
        win_oh_o  = 4'b0001 << cand;
      end
    end
  end

endmodule

// File: rtl/sdram_port_sched.sv
// Four-port SDRAM burst scheduler: round-robin grant, one burst command at a
// time, per-port frame address pointers with wrap and deferred reload.
module sdram_port_sched
  import sdram_sched_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int WR_LEN      = 256,
  parameter int RD_LEN      = 128,
  parameter int BUF_A_BASE  = 0,
  parameter int BUF_B_BASE  = 307200,
  parameter int FRAME_WORDS = 307200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_done,
  input  logic [3:0]           req,
  input  logic [3:0]           load,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 cmd_write,
  output logic [1:0]           cmd_port,
  output logic [ADDR_W-1:0]    cmd_addr,
  output logic [CMD_LEN_W-1:0] cmd_len,
  input  logic                 burst_done,
  output logic [3:0]           grant,
  output logic [3:0]           frame_wrap
);

  localparam int AW1 = ADDR_W + 1;
  localparam logic [CMD_LEN_W-1:0] WR_LEN_C = CMD_LEN_W'(WR_LEN);
  localparam logic [CMD_LEN_W-1:0] RD_LEN_C = CMD_LEN_W'(RD_LEN);
  localparam logic [ADDR_W-1:0]    BASE_A   = ADDR_W'(BUF_A_BASE);
  localparam logic [ADDR_W-1:0]    BASE_B   = ADDR_W'(BUF_B_BASE);
  localparam logic [AW1-1:0]       END_A    = AW1'(BUF_A_BASE + FRAME_WORDS);
  localparam logic [AW1-1:0]       END_B    = AW1'(BUF_B_BASE + FRAME_WORDS);

  // Ports 0 and 2 share buffer A, ports 1 and 3 share buffer B.
  function automatic logic [ADDR_W-1:0] port_base(input logic [1:0] p);
    return (p == WR1 || p == RD1) ? BASE_A : BASE_B;
  endfunction

  function automatic logic [AW1-1:0] port_end(input logic [1:0] p);
    return (p == WR1 || p == RD1) ? END_A : END_B;
  endfunction

  state_e                state_q, state_d;
  logic [1:0]            last_port_q, last_port_d;
  logic [ADDR_W-1:0]     ptr_q [4];
  logic [ADDR_W-1:0]     ptr_d [4];
  logic [3:0]            ld_pend_q, ld_pend_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_write_q, cmd_write_d;
  logic [1:0]            cmd_port_q, cmd_port_d;
  logic [ADDR_W-1:0]     cmd_addr_q, cmd_addr_d;
  logic [CMD_LEN_W-1:0]  cmd_len_q, cmd_len_d;
  logic [3:0]            grant_q, grant_d;
  logic [3:0]            frame_wrap_q, frame_wrap_d;

  logic [3:0]            win_oh;
  logic [1:0]            win_idx;
  logic                  win_vld;
  logic                  start;
  logic [3:0]            busy;
  logic [AW1-1:0]        next_ptr;

  rr_arb4 u_arb (
    .req_i       (req),
    .last_port_i (last_port_q),
    .win_oh_o    (win_oh),
    .win_idx_o   (win_idx),
    .win_vld_o   (win_vld)
  );

  assign start    = (state_q == ST_IDLE) && init_done && win_vld;
  // A port being granted this cycle already counts as busy for reloads.
  assign busy     = grant_q | (start ? win_oh : 4'b0000);
  assign next_ptr = {1'b0, ptr_q[cmd_port_q]} + AW1'(cmd_len_q);

  always_comb begin
    state_d      = state_q;
    last_port_d  = last_port_q;
    ptr_d        = ptr_q;
    ld_pend_d    = ld_pend_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_write_d  = cmd_write_q;
    cmd_port_d   = cmd_port_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_len_d    = cmd_len_q;
    grant_d      = grant_q;
    frame_wrap_d = 4'b0000;

    for (int i = 0; i < 4; i++) begin
      if (load[i]) begin
        if (busy[i]) ld_pend_d[i] = 1'b1;
        else         ptr_d[i]     = port_base(2'(i));
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_CMD;
          cmd_valid_d = 1'b1;
          cmd_port_d  = win_idx;
          cmd_write_d = ~win_idx[1];
          cmd_addr_d  = ptr_q[win_idx];
          cmd_len_d   = win_idx[1] ? RD_LEN_C : WR_LEN_C;
          grant_d     = win_oh;
        end
      end
      ST_CMD: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (burst_done) begin
          state_d     = ST_IDLE;
          grant_d     = 4'b0000;
          last_port_d = cmd_port_q;
          if (ld_pend_q[cmd_port_q] || load[cmd_port_q]) begin
            ptr_d[cmd_port_q]     = port_base(cmd_port_q);
            ld_pend_d[cmd_port_q] = 1'b0;
          end else if (next_ptr >= port_end(cmd_port_q)) begin
            ptr_d[cmd_port_q]        = port_base(cmd_port_q);
            frame_wrap_d[cmd_port_q] = 1'b1;
          end else begin
            ptr_d[cmd_port_q] = next_ptr[ADDR_W-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_port_q  <= RD2;
      ld_pend_q    <= 4'b0000;
      cmd_valid_q  <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_port_q   <= 2'd0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
      grant_q      <= 4'b0000;
      frame_wrap_q <= 4'b0000;
      // NOTE: the pointer array is four flops, not RAM, so resetting it is fine.
      for (int i = 0; i < 4; i++) ptr_q[i] <= port_base(2'(i));
    end else begin
      state_q      <= state_d;
      last_port_q  <= last_port_d;
      ld_pend_q    <= ld_pend_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_write_q  <= cmd_write_d;
      cmd_port_q   <= cmd_port_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_len_q    <= cmd_len_d;
      grant_q      <= grant_d;
      frame_wrap_q <= frame_wrap_d;
      for (int i = 0; i < 4; i++) ptr_q[i] <= ptr_d[i];
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_write  = cmd_write_q;
  assign cmd_port   = cmd_port_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_len    = cmd_len_q;
  assign grant      = grant_q;
  assign frame_wrap = frame_wrap_q;

endmodule

// File: tb/tb_sdram_port_sched.sv
// Scoreboard bench for sdram_port_sched: directed stimulus pushes expected
// commands; a monitor compares them on every accepted command.
module tb_sdram_port_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  load = 4'b0000;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        cmd_write;
  logic [1:0]  cmd_port;
  logic [23:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic        burst_done = 1'b0;
  logic [3:0]  grant;
  logic [3:0]  frame_wrap;

  sdram_port_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_done  (init_done),
    .req        (req),
    .load       (load),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_port   (cmd_port),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .burst_done (burst_done),
    .grant      (grant),
    .frame_wrap (frame_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  port;
    logic [23:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fw_cnt [4] = '{0, 0, 0, 0};
  logic [3:0] fw_prev = 4'b0000;
  int   done_delay = 10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] port, input logic [23:0] addr);
    exp_t e;
    e.port = port;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  // Monitor: compare each accepted command against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_cmd: got port %0d addr %0d, expected no command", cmd_port, cmd_addr);
        end else begin
          e = exp_q.pop_front();
          check("cmd_port",  32'(cmd_port),  32'(e.port));
          check("cmd_addr",  32'(cmd_addr),  32'(e.addr));
          check("cmd_write", 32'(cmd_write), (e.port < 2) ? 32'd1 : 32'd0);
          check("cmd_len",   32'(cmd_len),   (e.port < 2) ? 32'd256 : 32'd128);
          check("grant",     32'(grant),     32'(4'b0001 << e.port));
        end
      end
      if (rst_n && frame_wrap != 4'b0000) begin
        check("frame_wrap_width", 32'(frame_wrap & fw_prev), 32'd0);
        for (int i = 0; i < 4; i++) if (frame_wrap[i]) fw_cnt[i]++;
      end
      fw_prev = frame_wrap;
    end
  end

  // Command engine model: burst_done done_delay cycles after each accept,
  // suppressed if reset hits while the burst is running.
  initial begin
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_valid && cmd_ready) begin
        aborted = 1'b0;
        @(posedge clk);
        for (int k = 0; k < done_delay; k++) begin
          @(posedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted) begin
          #1 burst_done = 1'b1;
          @(posedge clk);
          #1 burst_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 req = 4'b0000;
    n = 0;
    while ((grant != 4'b0000 || cmd_valid) && n < max) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, 32'(grant), 32'd0);
    cyc(2);
  endtask

  task automatic wait_wait_state(input logic [3:0] g, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(grant == g && !cmd_valid) && n < 50);
    check(name, 32'(grant), 32'(g));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    int lat;
    int wrap0;

    // Reset values
    cyc(2);
    @(negedge clk);
    check("rst_cmd_valid",  32'(cmd_valid),  32'd0);
    check("rst_grant",      32'(grant),      32'd0);
    check("rst_cmd_addr",   32'(cmd_addr),   32'd0);
    check("rst_cmd_len",    32'(cmd_len),    32'd0);
    check("rst_cmd_port",   32'(cmd_port),   32'd0);
    check("rst_cmd_write",  32'(cmd_write),  32'd0);
    check("rst_frame_wrap", 32'(frame_wrap), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(2);

    // Round-robin order with all ports requesting
    push(2'd0, 24'd0);
    push(2'd1, 24'd307200);
    push(2'd2, 24'd0);
    push(2'd3, 24'd307200);
    push(2'd0, 24'd256);
    init_done = 1'b1;
    req = 4'b1111;
    drain("rr_order", 500);

    // Back-pressure: cmd_ready low for 5 cycles, outputs must hold
    cmd_ready = 1'b0;
    req = 4'b0010;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cmd_valid && lat < 20);
    check("bp_valid_seen", 32'(cmd_valid), 32'd1);
    push(2'd1, 24'd307456);
    for (int i = 0; i < 5; i++) begin
      check("bp_cmd_valid", 32'(cmd_valid), 32'd1);
      check("bp_cmd_port",  32'(cmd_port),  32'd1);
      check("bp_cmd_addr",  32'(cmd_addr),  32'd307456);
      check("bp_cmd_len",   32'(cmd_len),   32'd256);
      check("bp_cmd_write", 32'(cmd_write), 32'd1);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 cmd_ready = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_dropped", 32'(cmd_valid), 32'd0);
    check("bp_wait_grant",    32'(grant),     32'b0010);
    drain("bp", 100);

    // Reload during a port-3 burst is deferred to burst_done, no wrap pulse
    push(2'd3, 24'd307328);
    push(2'd3, 24'd307200);
    req = 4'b1000;
    wait_wait_state(4'b1000, "load_wait_grant");
    @(posedge clk);
    #1 load = 4'b1000;
    @(posedge clk);
    #1 load = 4'b0000;
    @(negedge clk);
    check("load_addr_held", 32'(cmd_addr), 32'd307328);
    drain("load", 200);
    check("load_no_wrap", 32'(fw_cnt[3]), 32'd0);

    // Stray burst_done in IDLE must not move any pointer
    @(posedge clk);
    #1 burst_done = 1'b1;
    @(posedge clk);
    #1 burst_done = 1'b0;
    cyc(1);

    // init_done gating and latency
    init_done = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gated_cmd_valid", 32'(cmd_valid), 32'd0);
    end
    push(2'd0, 24'd512);
    @(posedge clk);
    #1 init_done = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cmd_valid && lat < 4);
    check("init_latency_le2", (lat >= 1 && lat <= 2) ? 32'd1 : 32'd0, 32'd1);
    drain("init", 100);

    // Reset during WAIT aborts the burst and restores start-up state
    push(2'd2, 24'd128);
    req = 4'b0100;
    wait_wait_state(4'b0100, "rst_wait_grant");
    @(posedge clk);
    #1 rst_n = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    check("mid_rst_cmd_valid",  32'(cmd_valid),  32'd0);
    check("mid_rst_grant",      32'(grant),      32'd0);
    check("mid_rst_cmd_addr",   32'(cmd_addr),   32'd0);
    check("mid_rst_cmd_len",    32'(cmd_len),    32'd0);
    check("mid_rst_cmd_port",   32'(cmd_port),   32'd0);
    check("mid_rst_frame_wrap", 32'(frame_wrap), 32'd0);
    check("mid_rst_sb_empty",   32'(exp_q.size()), 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(12);
    push(2'd0, 24'd0);
    req = 4'b1111;
    drain("post_rst", 100);

    // Frame wrap of port 0 after 1200 bursts of 256 words
    do_reset();
    done_delay = 1;
    wrap0 = fw_cnt[0];
    for (int k = 0; k < 1200; k++) push(2'd0, 24'(k * 256));
    push(2'd0, 24'd0);
    req = 4'b0001;
    drain("wrap", 20000);
    check("wrap_pulse_count", 32'(fw_cnt[0] - wrap0), 32'd1);
    check("wrap_other_ports", 32'(fw_cnt[1] + fw_cnt[2] + fw_cnt[3]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
